// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the memory arbiter between the I-cache, D-cache fills and D-cache stores.
package mem_arb_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned WORDS      = 8;
  localparam int unsigned WORD_IDX_W = $clog2(WORDS);
  localparam int unsigned BLK_OFF_W  = $clog2(2 * WORDS);

  typedef enum logic [1:0] {IDLE, WRITE, ISSUE, DRAIN} arb_state_t;
  typedef enum logic {REQ_IC, REQ_DC} requester_t;

  // Aligns any byte address down to the start of its block.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:BLK_OFF_W], BLK_OFF_W'(0)};
  endfunction

endpackage

// File: rtl/mem_arbiter_adder_16bit.sv
// Plain 16-bit modulo adder used to form per-word fill addresses.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mem_arbiter_fill_word_counter.sv
// Word counter for block fills: synchronous clear, count enable and terminal-count flag.
module fill_word_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_IDX_W,
  parameter int unsigned LAST  = WORDS - 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == WIDTH'(LAST));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between I-cache fills, D-cache fills and D-cache stores,
// issuing burst reads for a fill and steering the returning words to the owning cache.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req,
  input  logic [ADDR_W-1:0]     ic_addr,
  input  logic                  dc_req,
  input  logic [ADDR_W-1:0]     dc_addr,
  input  logic                  dc_wr_req,
  input  logic [ADDR_W-1:0]     dc_wr_addr,
  input  logic [DATA_W-1:0]     dc_wr_data,
  output logic                  ic_grant,
  output logic                  dc_grant,
  output logic                  ic_data_valid,
  output logic                  dc_data_valid,
  output logic [WORD_IDX_W-1:0] fill_word_idx,
  output logic [DATA_W-1:0]     fill_data,
  output logic                  ic_done,
  output logic                  dc_done,
  output logic                  dc_wr_ack,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_data_valid
);

  arb_state_t              state, state_next;
  requester_t              owner, owner_next;
  requester_t              last_fill, last_fill_next;
  logic                    last_was_wr, last_was_wr_next;
  logic [ADDR_W-1:0]       base, base_next;
  logic [ADDR_W-1:0]       issue_addr;
  logic [WORD_IDX_W-1:0]   issue_cnt, recv_cnt;
  logic                    issue_tc, recv_tc;
  logic                    filling, receiving, fill_last;

  assign filling   = (state == ISSUE) || (state == DRAIN);
  assign receiving = filling && mem_data_valid;
  assign fill_last = receiving && recv_tc;
  assign fill_data = mem_rdata;

  fill_word_counter u_issue_cnt (
    .clk   (clk),
    .clr   (rst || ((state == ISSUE) && issue_tc)),
    .en    (state == ISSUE),
    .count (issue_cnt),
    .tc    (issue_tc)
  );

  fill_word_counter u_recv_cnt (
    .clk   (clk),
    .clr   (rst || fill_last),
    .en    (receiving),
    .count (recv_cnt),
    .tc    (recv_tc)
  );

  adder_16bit u_addr_add (
    .a   (base),
    .b   (ADDR_W'({issue_cnt, 1'b0})),
    .sum (issue_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= REQ_IC;
      last_fill   <= REQ_DC;
      last_was_wr <= 1'b0;
      base        <= '0;
    end else begin
      state       <= state_next;
      owner       <= owner_next;
      last_fill   <= last_fill_next;
      last_was_wr <= last_was_wr_next;
      base        <= base_next;
    end
  end

  // A store yields to pending fills once in a row so neither side can starve the other.
  always_comb begin
    state_next       = state;
    owner_next       = owner;
    last_fill_next   = last_fill;
    last_was_wr_next = last_was_wr;
    base_next        = base;
    case (state)
      IDLE: begin
        if (dc_wr_req && !(last_was_wr && (ic_req || dc_req))) begin
          state_next       = WRITE;
          last_was_wr_next = 1'b1;
        end else if (ic_req || dc_req) begin
          state_next       = ISSUE;
          last_was_wr_next = 1'b0;
          if (ic_req && (!dc_req || (last_fill == REQ_DC))) begin
            owner_next = REQ_IC;
            base_next  = block_base(ic_addr);
          end else begin
            owner_next = REQ_DC;
            base_next  = block_base(dc_addr);
          end
        end
      end
      WRITE:   state_next = IDLE;
      ISSUE:   if (issue_tc) state_next = DRAIN;
      default: ;
    endcase
    if (fill_last) begin
      state_next     = IDLE;
      last_fill_next = owner;
    end
  end

  always_comb begin
    ic_grant      = 1'b0;
    dc_grant      = 1'b0;
    ic_data_valid = 1'b0;
    dc_data_valid = 1'b0;
    fill_word_idx = '0;
    ic_done       = 1'b0;
    dc_done       = 1'b0;
    dc_wr_ack     = 1'b0;
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state)
      WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = dc_wr_addr;
        mem_wdata  = dc_wr_data;
        dc_wr_ack  = 1'b1;
      end
      ISSUE: begin
        mem_enable = 1'b1;
        mem_addr   = issue_addr;
      end
      default: ;
    endcase
    if (filling) begin
      ic_grant = (owner == REQ_IC);
      dc_grant = (owner == REQ_DC);
    end
    if (receiving) begin
      fill_word_idx = recv_cnt;
      ic_data_valid = (owner == REQ_IC);
      dc_data_valid = (owner == REQ_DC);
      ic_done       = recv_tc && (owner == REQ_IC);
      dc_done       = recv_tc && (owner == REQ_DC);
    end
  end

endmodule
